// File: rtl/noise_gate_pkg.sv
// Shared types for the noise gate: gate state encoding and the Q1.15 unity helper.
package noise_gate_pkg;

  typedef enum logic [2:0] {
    CLOSED  = 3'd0,
    ATTACK  = 3'd1,
    OPEN    = 3'd2,
    HOLD    = 3'd3,
    RELEASE = 3'd4
  } gate_state_e;

  // Unity gain for an unsigned Q1.(w-1) gain word.
  function automatic logic [63:0] gain_unity(input int gain_w);
    return 64'd1 << (gain_w - 1);
  endfunction

endpackage

// File: rtl/noise_gate_vca.sv
// Registered gain stage: dout = sat((din * gain) >>> (GAIN_W-1)), or din when bypassed.
module noise_gate_vca #(
  parameter int DATA_W = 16,
  parameter int GAIN_W = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     en,
  input  logic                     bypass,
  input  logic signed [DATA_W-1:0] din,
  input  logic        [GAIN_W-1:0] gain,
  output logic signed [DATA_W-1:0] dout
);

  localparam int P = DATA_W + GAIN_W + 1;
  localparam logic signed [P-1:0] SAT_HI = {{(GAIN_W+2){1'b0}}, {(DATA_W-1){1'b1}}};
  localparam logic signed [P-1:0] SAT_LO = {{(GAIN_W+2){1'b1}}, {(DATA_W-1){1'b0}}};

  logic signed [P-1:0]      din_x;
  logic signed [P-1:0]      gain_x;
  logic signed [P-1:0]      prod;
  logic signed [P-1:0]      shifted;
  logic signed [DATA_W-1:0] scaled;

  assign din_x   = P'(din);
  assign gain_x  = $signed({{(DATA_W+1){1'b0}}, gain});
  assign prod    = din_x * gain_x;
  assign shifted = prod >>> (GAIN_W - 1);

  // Gain never exceeds unity in normal use; the clamp only covers misconfiguration.
  always_comb begin
    scaled = shifted[DATA_W-1:0];
    if (shifted > SAT_HI)      scaled = SAT_HI[DATA_W-1:0];
    else if (shifted < SAT_LO) scaled = SAT_LO[DATA_W-1:0];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)      dout <= '0;
    else if (en)     dout <= bypass ? din : scaled;
  end

endmodule

// File: rtl/noise_gate_core.sv
// Noise gate: hysteretic threshold compare, gate FSM with hold timer, Q1.15 gain ramp, VCA.
//
//   state   | meaning
//   CLOSED  | gain held at 0, waiting for env >= thresh_open
//   ATTACK  | gain ramps up by attack_step toward unity
//   OPEN    | gain at unity, waiting for env < thresh_close
//   HOLD    | gain at unity, hold counter running down
//   RELEASE | gain ramps down by release_step toward 0
module noise_gate_core
  import noise_gate_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int GAIN_W = 16,
  parameter int HOLD_W = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     en,
  input  logic                     bypass,
  input  logic        [DATA_W-1:0] thresh_open,
  input  logic        [DATA_W-1:0] thresh_close,
  input  logic        [HOLD_W-1:0] hold_len,
  input  logic        [GAIN_W-1:0] attack_step,
  input  logic        [GAIN_W-1:0] release_step,
  input  logic        [DATA_W-1:0] env,
  input  logic signed [DATA_W-1:0] din,
  output logic signed [DATA_W-1:0] dout,
  output logic                     gate_open,
  output logic        [GAIN_W-1:0] gain_out
);

  localparam logic [GAIN_W-1:0] UNITY = GAIN_W'(gain_unity(GAIN_W));

  gate_state_e       state, state_nxt;
  logic [GAIN_W-1:0] gain, gain_nxt;
  logic [HOLD_W-1:0] hold_cnt, hold_nxt;

  logic              is_open, is_close;
  logic [GAIN_W:0]   atk_sum;
  logic [GAIN_W-1:0] atk_gain;
  logic [GAIN_W-1:0] rel_gain;

  assign is_open  = (env >= thresh_open);
  assign is_close = (env <  thresh_close);

  // A zero step means an instant ramp rather than a stuck one.
  assign atk_sum  = {1'b0, gain} + {1'b0, attack_step};
  assign atk_gain = (attack_step == '0 || atk_sum >= {1'b0, UNITY}) ? UNITY : atk_sum[GAIN_W-1:0];
  assign rel_gain = (release_step == '0 || gain <= release_step) ? '0 : gain - release_step;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= CLOSED;
      gain     <= '0;
      hold_cnt <= '0;
    end else if (en) begin
      state    <= state_nxt;
      gain     <= gain_nxt;
      hold_cnt <= hold_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    gain_nxt  = gain;
    hold_nxt  = hold_cnt;
    unique case (state)
      CLOSED: begin
        gain_nxt = '0;
        if (is_open) state_nxt = ATTACK;
      end
      ATTACK: begin
        if (is_close && !is_open) begin
          state_nxt = RELEASE;
        end else begin
          gain_nxt = atk_gain;
          if (atk_gain == UNITY) state_nxt = OPEN;
        end
      end
      OPEN: begin
        gain_nxt = UNITY;
        if (!is_open && is_close) begin
          if (hold_len == '0) begin
            state_nxt = RELEASE;
          end else begin
            hold_nxt  = hold_len;
            state_nxt = HOLD;
          end
        end
      end
      HOLD: begin
        if (is_open) begin
          state_nxt = OPEN;
        end else if (hold_cnt <= HOLD_W'(1)) begin
          hold_nxt  = '0;
          state_nxt = RELEASE;
        end else begin
          hold_nxt = hold_cnt - HOLD_W'(1);
        end
      end
      RELEASE: begin
        if (is_open) begin
          state_nxt = ATTACK;
        end else begin
          gain_nxt = rel_gain;
          if (rel_gain == '0) state_nxt = CLOSED;
        end
      end
      default: begin
        state_nxt = CLOSED;
        gain_nxt  = '0;
        hold_nxt  = '0;
      end
    endcase
  end

  assign gate_open = (state == ATTACK) || (state == OPEN) || (state == HOLD);
  assign gain_out  = gain;

  noise_gate_vca #(
    .DATA_W (DATA_W),
    .GAIN_W (GAIN_W)
  ) u_vca (
    .clk    (clk),
    .rst_n  (rst_n),
    .en     (en),
    .bypass (bypass),
    .din    (din),
    .gain   (gain),
    .dout   (dout)
  );

endmodule

// File: tb/tb_noise_gate_core.sv
// Directed scoreboard bench for noise_gate_core: stimulus queues expected outputs per clock, a monitor checks them.
module tb_noise_gate_core;

  logic               clk = 1'b0;
  logic               rst_n = 1'b0;
  logic               en = 1'b1;
  logic               bypass = 1'b0;
  logic        [15:0] thresh_open = 16'd8000;
  logic        [15:0] thresh_close = 16'd4000;
  logic        [15:0] hold_len = 16'd5;
  logic        [15:0] attack_step = 16'h2000;
  logic        [15:0] release_step = 16'h1000;
  logic        [15:0] env = 16'd0;
  logic signed [15:0] din = 16'sd0;
  logic signed [15:0] dout;
  logic               gate_open;
  logic        [15:0] gain_out;

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    string              nm;
    logic signed [15:0] dout;
    logic        [15:0] gain;
    logic               gate;
  } exp_t;

  exp_t sbq[$];

  noise_gate_core #(.DATA_W(16), .GAIN_W(16), .HOLD_W(16)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .en           (en),
    .bypass       (bypass),
    .thresh_open  (thresh_open),
    .thresh_close (thresh_close),
    .hold_len     (hold_len),
    .attack_step  (attack_step),
    .release_step (release_step),
    .env          (env),
    .din          (din),
    .dout         (dout),
    .gate_open    (gate_open),
    .gain_out     (gain_out)
  );

  always #5 clk = ~clk;

  function automatic void check(input string nm, input int act, input int req);
    n_tests++;
    if (act != req) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, req, $time);
    end
  endfunction

  // Monitor: every clock edge is an output event for this block.
  always @(posedge clk) begin
    #1;
    if (sbq.size() != 0) begin
      exp_t e;
      e = sbq.pop_front();
      check({e.nm, ".dout"},      int'(dout),      int'(e.dout));
      check({e.nm, ".gain"},      int'(gain_out),  int'(e.gain));
      check({e.nm, ".gate_open"}, int'(gate_open), int'(e.gate));
    end
  end

  task automatic step(input string nm, input int e_dout, input int e_gain, input bit e_gate);
    exp_t e;
    e.nm   = nm;
    e.dout = 16'(e_dout);
    e.gain = 16'(e_gain);
    e.gate = e_gate;
    sbq.push_back(e);
    @(negedge clk);
  endtask

  initial begin
    repeat (10) @(negedge clk);
    rst_n = 1'b1;

    // reset state
    repeat (3) step("reset", 0, 0, 0);

    // attack ramp
    env = 16'd10000; din = 16'sd10000;
    step("atk_enter", 0, 'h0000, 1);
    step("atk1",      0, 'h2000, 1);
    step("atk2",   2500, 'h4000, 1);
    step("atk3",   5000, 'h6000, 1);
    step("atk4",   7500, 'h8000, 1);
    step("open",  10000, 'h8000, 1);

    // hysteresis while open
    env = 16'd6000;
    repeat (3) step("hyst_open", 10000, 'h8000, 1);

    // hold then release
    env = 16'd2000;
    repeat (5) step("hold", 10000, 'h8000, 1);
    step("hold_end", 10000, 'h8000, 0);
    for (int i = 1; i <= 8; i++) step("release", 1250 * (9 - i), 'h8000 - 'h1000 * i, 0);
    step("closed", 0, 0, 0);

    // hysteresis while closed
    env = 16'd6000;
    repeat (2) step("hyst_closed", 0, 0, 0);

    // instant attack, retrigger in hold, full hold reload
    env = 16'd10000; attack_step = 16'h0000;
    step("inst_enter",  0, 'h0000, 1);
    step("inst_attack", 0, 'h8000, 1);
    step("inst_open", 10000, 'h8000, 1);
    env = 16'd2000;
    repeat (3) step("hold_pre", 10000, 'h8000, 1);
    env = 16'd9000;
    step("retrig", 10000, 'h8000, 1);
    env = 16'd2000;
    repeat (5) step("hold_reload", 10000, 'h8000, 1);
    step("hold_reload_end", 10000, 'h8000, 0);
    release_step = 16'h0000;
    step("inst_release", 10000, 0, 0);
    step("closed2", 0, 0, 0);

    // arithmetic corners
    din = -16'sd32768; env = 16'd10000;
    step("neg_enter", 0, 'h0000, 1);
    step("neg_ramp",  0, 'h8000, 1);
    step("neg_unity", -32768, 'h8000, 1);
    hold_len = 16'd0; env = 16'd2000;
    step("hold_zero", -32768, 'h8000, 0);
    step("rel_zero",  -32768, 'h0000, 0);
    attack_step = 16'h4000; env = 16'd10000;
    step("half_enter", 0, 'h0000, 1);
    step("half_ramp",  0, 'h4000, 1);
    env = 16'd2000; release_step = 16'h1000;
    step("atk_abort", -16384, 'h4000, 0);
    din = -16'sd1;
    step("floor", -1, 'h3000, 0);

    // en low freezes everything mid-release
    en = 1'b0; din = 16'sd12345;
    repeat (10) step("freeze", -1, 'h3000, 0);
    en = 1'b1; din = -16'sd32768;
    step("resume1", -12288, 'h2000, 0);
    step("resume2",  -8192, 'h1000, 0);
    step("resume3",  -4096, 'h0000, 0);
    step("closed3",      0, 'h0000, 0);

    // bypass while closed
    env = 16'd0; bypass = 1'b1; din = 16'sd10000;
    step("bypass_pos", 10000, 0, 0);
    din = -16'sd5000;
    step("bypass_neg", -5000, 0, 0);
    bypass = 1'b0;
    step("unbypass", 0, 0, 0);

    // asynchronous reset mid-ramp
    env = 16'd10000; attack_step = 16'h2000; din = 16'sd10000;
    step("ramp_enter", 0, 'h0000, 1);
    step("ramp1",      0, 'h2000, 1);
    step("ramp2",   2500, 'h4000, 1);
    #2 rst_n = 1'b0;
    #1;
    check("async_rst.gain", int'(gain_out), 0);
    check("async_rst.dout", int'(dout), 0);
    check("async_rst.gate_open", int'(gate_open), 0);

    repeat (4) @(negedge clk);
    check("scoreboard_drained", sbq.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
